// File: rtl/regfile_ctrl_pkg.sv
// Shared types and sizes for the register file writeback arbiter.
// Holds data/address widths, the arbiter state enum and counter width.
package regfile_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;
  localparam int CNT_W  = 4;

  typedef enum logic {
    M_PRIO = 1'b0,
    A_PRIO = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard, one bit per register; a set on the same bit
// as a clear in one cycle wins. Ports: set/clr strobes + addrs, pending_o.
module rf_scoreboard
  import regfile_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  output logic [NREG-1:0]   pending_o
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d[clr_addr_i] = 1'b0;
    // applied last: a newer issue keeps the bit outstanding
    if (set_i) pend_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU (A) and load (M) writebacks onto the regfile write port.
// Ports: A/M valid-ready requests, issue strobe, registered rf_* write, pending.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   pending
);

  localparam logic [CNT_W-1:0] SMAX    = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] SMAX_M1 = CNT_W'(STARVE_MAX - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              a_gnt, m_gnt;

  // readies are gated by clear so they drop the instant reset asserts
  always_comb begin
    a_gnt = 1'b0;
    m_gnt = 1'b0;
    if (clear) begin
      unique case (state_q)
        M_PRIO: begin
          m_gnt = m_valid;
          a_gnt = a_valid && !m_valid;
        end
        A_PRIO: begin
          a_gnt = a_valid;
          m_gnt = m_valid && !a_valid;
        end
        default: ;
      endcase
    end
  end

  assign a_ready = a_gnt;
  assign m_ready = m_gnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (a_gnt || !a_valid) begin
      cnt_d = '0;
    end else if (cnt_q != SMAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      M_PRIO: begin
        if (a_valid && !a_gnt && cnt_q == SMAX_M1)
          state_d = A_PRIO;
      end
      A_PRIO: begin
        if (a_gnt || !a_valid)
          state_d = M_PRIO;
      end
      default: state_d = M_PRIO;
    endcase
  end

  // address/data only move on a grant; idle cycles keep the last write
  always_comb begin
    we_d    = a_gnt || m_gnt;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (a_gnt) begin
      waddr_d = a_addr;
      wdata_d = a_data;
    end else if (m_gnt) begin
      waddr_d = m_addr;
      wdata_d = m_data;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= M_PRIO;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

  rf_scoreboard u_sb (
    .clk        (clk),
    .clear      (clear),
    .set_i      (iss_valid),
    .set_addr_i (iss_addr),
    .clr_i      (we_q),
    .clr_addr_i (waddr_q),
    .pending_o  (pending)
  );

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port (write address, write enable, write data) of the 16x32 register file.
- Shares that port between two writeback requesters: execute/ALU (port A) and memory-load (port M). Each uses a valid/ready handshake.
- Keeps a 16-bit pending-write scoreboard so issue logic can stall on read-after-write hazards.
- Sits between the pipeline writeback stages and the register file.

Parameters:
DATA_W, 32, width of the write data and the register file word
ADDR_W, 4, register address width
NREG, 16, number of registers; equals 2**ADDR_W
STARVE_MAX, 3, consecutive denied cycles of port A before A gets priority for one grant; legal range 1..15

Ports:
clk  input  1  clock; all state updates on the rising edge
clear  input  1  asynchronous active-low reset
a_valid  input  1  ALU writeback request
a_ready  output  1  ALU request granted this cycle (combinational)
a_addr  input  ADDR_W  ALU destination register
a_data  input  DATA_W  ALU result
m_valid  input  1  load writeback request
m_ready  output  1  load request granted this cycle (combinational)
m_addr  input  ADDR_W  load destination register
m_data  input  DATA_W  load data
iss_valid  input  1  an instruction with a destination register issued this cycle
iss_addr  input  ADDR_W  destination register of the issued instruction
rf_we  output  1  register file write enable (registered)
rf_waddr  output  ADDR_W  register file write address (registered)
rf_wdata  output  DATA_W  register file write data (registered)
pending  output  NREG  scoreboard; bit i=1 means a write to register i is outstanding

Behaviour:
- Reset (clear=0, asynchronous): the following take effect immediately and hold while clear=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, pending=0.
  - state=M_PRIO, starve_cnt=0.
  - a_ready=0 and m_ready=0 (forced).
- Handshake:
  - A transfer occurs on a port when valid&&ready at a rising edge.
  - A requester holds valid high, with address and data stable, until it sees ready.
  - Ready depends combinationally on both valids and the state. Ready never asserts while its own valid is low.
  - At most one ready is high per cycle.
- FSM, two states:
  - M_PRIO: if m_valid, grant M; else grant A if a_valid.
  - A_PRIO: if a_valid, grant A; else grant M if m_valid.
  - Transitions:
    - M_PRIO -> A_PRIO when a_valid && !a_ready && starve_cnt==STARVE_MAX-1.
    - A_PRIO -> M_PRIO on an A grant, or when a_valid=0.
- Starvation counter (starve_cnt, 4 bits):
  - Increments, saturating at STARVE_MAX, each cycle a_valid && !a_ready.
  - Clears on an A grant or when a_valid=0.
- Latency:
  - A grant in cycle N drives rf_we=1 with the granted address and data in cycle N+1.
  - The register file captures the data at the end of N+1.
  - Back-to-back grants give one write per cycle, so throughput is 1 per cycle.
  - A cycle with no grant gives rf_we=0 the next cycle. rf_waddr and rf_wdata hold their last values.
- Scoreboard:
  - iss_valid sets pending[iss_addr] at the edge.
  - A cycle with rf_we=1 clears pending[rf_waddr] at the end of that cycle, i.e. once the data is in the register file.
  - If a set and a clear hit the same bit in the same cycle, the set wins (the newer write is outstanding).
  - Set and clear on different bits both take effect.
- No hardwired-zero register: writes to address 0 are performed like any other.
- A write to a register whose pending bit is 0 is legal. The clear is then a no-op.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - DATA_W, ADDR_W, NREG
  - the arbiter state enum (M_PRIO, A_PRIO)
  - the starve counter width
- One sub-module, rf_scoreboard:
  - Contains the NREG-bit pending vector.
  - Inputs: set strobe + address, clear strobe + address. Implements the set-wins rule.
  - Has its own async active-low clear.
- Arbiter FSM, starve counter and output registers live in regfile_wb_arbiter.

Test Plan:
- Reset: drive clear=0 mid-run with rf_we=1 and pending=16'h00A0.
  - rf_we, rf_waddr, rf_wdata and pending go to 0 immediately, and both readies read 0.
  - After release, the first grant goes to M when both ports are valid.
- Single ALU write: a_valid=1, a_addr=5, a_data=32'hDEADBEEF.
  - a_ready=1 the same cycle.
  - Next cycle: rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF.
  - Following cycle: rf_we=0.
- Contention, STARVE_MAX=3: a_valid=m_valid=1 held for 8 cycles with fresh payloads each transfer.
  - Grants run M,M,M,A,M,M,M,A.
  - starve_cnt runs 1,2,3,0 repeating.
  - No cycle has both readies high.
- M-only traffic: m_valid=1 for 6 cycles with a_valid=0.
  - Six M grants; starve_cnt stays 0; state stays M_PRIO.
- Scoreboard: iss_valid with iss_addr=7, then an ALU write to 7.
  - pending[7] is 1 until the end of the rf_we cycle, then 0.
  - Repeat with iss_valid, iss_addr=7 in that same rf_we cycle: pending[7] stays 1.
- Hold under stall: m_valid stays high throughout; a_valid=1 with a_addr=3, a_data=1 held stable for 2 denied cycles.
  - The eventual write carries rf_waddr=3, rf_wdata=1 exactly once.
  - a_ready is never high while a_valid=0.
